gate_unit_pipe: RTL and testbench
=================================

// Module: gate_unit_pipe
// PURPOSE
//  Parametrised, registered successor to the quad 2-input AND part: a WIDTH-bit
//  two-operand logic unit with eight selectable functions. Operands enter and
//  results leave over valid/ready handshakes through a 2-entry skid buffer.
//  Full throughput is one result per clock. Sits between the register file and
//  the ALU result mux of the CPU datapath.
// PARAMETERS
//  WIDTH  4  operand/result width in bits (>=1)
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      asynchronous, active-low reset
//  in_valid   in   1      a/b/op valid this cycle
//  in_ready   out  1      unit can accept a/b/op this cycle
//  op         in   3      function select (see BEHAVIOUR)
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B
//  out_valid  out  1      y/zero/parity hold a result
//  out_ready  in   1      consumer takes result this cycle
//  y          out  WIDTH  result
//  zero       out  1      1 when y == 0
//  parity     out  1      XOR-reduce of y (odd parity)
// BEHAVIOUR
//  - op: 000 AND, 001 OR, 010 XOR, 011 NAND, 100 NOR, 101 XNOR, 110 A&~B,
//    111 ~A (b ignored).
//  - Input transfer = in_valid & in_ready; output transfer = out_valid & out_ready.
//  - Result computed combinationally from a/b/op and captured at the input
//    transfer edge. y/zero/parity are registered. Latency: out_valid rises the
//    cycle after the transfer.
//  - Storage: main register (drives outputs) + skid register; occupancy 0..2.
//    occ0: accept -> main. occ1: accept -> main if main drains this cycle,
//    else -> skid. occ2: no accept; on drain skid moves to main.
//  - in_ready = ~skid_valid (registered state only, no combinational path from
//    out_ready). A full unit therefore re-opens one cycle after the drain.
//  - While out_valid & ~out_ready: y/zero/parity/out_valid are held stable.
//  - Simultaneous accept and drain at occ1 leaves occupancy 1 and loads the
//    new result into main. Occupancy never exceeds 2; no data is dropped or
//    duplicated.
//  - Reset (async assert, sync release): out_valid=0, skid_valid=0, in_ready=1,
//    y=0, zero=0, parity=0. A reset mid-stream discards both entries at once.
//  - Ignored: op/a/b when in_valid=0; out_ready when out_valid=0.
// STRUCTURE
//  - gate_ops.vh (shared include): localparam opcodes OP_AND..OP_NOTA and the
//    function gate_eval(op,a,b) that the ALU also reuses.
//  - One sub-module, skid_reg #(.W(WIDTH+2)): generic 2-entry valid/ready
//    skid buffer. It carries {parity,zero,y}. Top level = gate_eval + flags +
//    skid_reg.
// TESTING
//  1 WIDTH=4, op=000, a=1010, b=1100, out_ready=1 -> next cycle y=1000,
//    zero=0, parity=1, out_valid=1 for exactly one cycle.
//  2 Sweep all 8 ops with a=1111, b=0101 -> y=0101,1111,1010,1010,0000,0101,
//    1010,0000. zero=1 for NOR and ~A. One result per cycle, in order.
//  3 Backpressure: out_ready=0, stream 3 vectors -> first two accepted,
//    in_ready=0 from cycle 2, y held; raise out_ready -> results drain in order,
//    in_ready=1 one cycle after the first drain.
//  4 occ1 with simultaneous accept+drain for 10 cycles -> out_valid stays 1,
//    no bubbles, in_ready stays 1.
//  5 Assert rst_n=0 mid-clock with occ=2 -> immediate out_valid=0, y=0,
//    in_ready=1. After release, the first new vector appears with latency 1.
//  6 WIDTH=8, op=010, a=8'hF0, b=8'hFF -> y=8'h0F, parity=0. Random
//    valid/ready vs a reference model for 1000 cycles -> zero mismatches.

Source files
------------

// File: rtl/gate_unit_pipe_pkg.sv
// gate_unit_pipe_pkg: opcodes and the per-bit gate function shared by the logic unit and the ALU.
package gate_unit_pipe_pkg;
  typedef enum logic [2:0] {
    OP_AND, OP_OR, OP_XOR, OP_NAND, OP_NOR, OP_XNOR, OP_ANDN, OP_NOTA
  } gate_op_e;
  function automatic logic gate_eval(input logic [2:0] op, input logic a, input logic b);
    gate_op_e o;
    o = gate_op_e'(op);
    return o == OP_AND  ? a & b :
           o == OP_OR   ? a | b :
           o == OP_XOR  ? a ^ b :
           o == OP_NAND ? ~(a & b) :
           o == OP_NOR  ? ~(a | b) :
           o == OP_XNOR ? ~(a ^ b) :
           o == OP_ANDN ? a & ~b : ~a;
  endfunction
endpackage

// File: rtl/gate_unit_pipe_if.sv
// gate_unit_pipe_if: operand and result valid/ready channels of the logic unit.
interface gate_unit_pipe_if #(parameter int WIDTH = 4);
  logic             in_valid, in_ready, out_valid, out_ready, zero, parity;
  logic [2:0]       op;
  logic [WIDTH-1:0] a, b, y;
  modport master (output in_valid, op, a, b, out_ready, input in_ready, out_valid, y, zero, parity);
  modport slave  (input in_valid, op, a, b, out_ready, output in_ready, out_valid, y, zero, parity);
endinterface

// File: rtl/gate_unit_pipe_skid.sv
// skid_reg: generic 2-entry valid/ready skid buffer; in_ready depends only on registered state.
module skid_reg #(parameter int W = 6) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o
);
  logic [W-1:0] main_q, main_d, skid_q, skid_d;
  logic         main_v_q, main_v_d, skid_v_q, skid_v_d, acc, drn;
  assign acc = in_valid_i & ~skid_v_q;
  assign drn = main_v_q & out_ready_i;
  // a draining main is refilled from skid first, otherwise from the input
  always_comb begin
    main_d   = drn & skid_v_q ? skid_q : (drn | ~main_v_q) & acc ? in_data_i : main_q;
    main_v_d = drn ? skid_v_q | acc : main_v_q | acc;
    skid_d   = acc & main_v_q & ~drn ? in_data_i : skid_q;
    skid_v_d = drn ? 1'b0 : skid_v_q | (acc & main_v_q);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      main_q   <= '0;
      skid_q   <= '0;
      main_v_q <= 1'b0;
      skid_v_q <= 1'b0;
    end else begin
      main_q   <= main_d;
      skid_q   <= skid_d;
      main_v_q <= main_v_d;
      skid_v_q <= skid_v_d;
    end
  assign in_ready_o  = ~skid_v_q;
  assign out_valid_o = main_v_q;
  assign out_data_o  = main_q;
endmodule

// File: rtl/gate_unit_pipe.sv
// gate_unit_pipe: WIDTH-bit 8-function logic unit; result and flags are computed on entry and
// carried through a skid buffer so outputs are registered.
module gate_unit_pipe import gate_unit_pipe_pkg::*; #(parameter int WIDTH = 4) (
  input logic             clk,
  input logic             rst_n,
  gate_unit_pipe_if.slave bus_if
);
  logic [WIDTH-1:0] y_w;
  logic [WIDTH+1:0] res_w;
  always_comb begin
    y_w = '0;
    for (int i = 0; i < WIDTH; i++) y_w[i] = gate_eval(bus_if.op, bus_if.a[i], bus_if.b[i]);
  end
  skid_reg #(.W(WIDTH+2)) u_skid (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid_i  (bus_if.in_valid),
    .in_ready_o  (bus_if.in_ready),
    .in_data_i   ({^y_w, ~|y_w, y_w}),
    .out_valid_o (bus_if.out_valid),
    .out_ready_i (bus_if.out_ready),
    .out_data_o  (res_w)
  );
  assign {bus_if.parity, bus_if.zero, bus_if.y} = res_w;
endmodule

// File: tb/tb_gate_unit_pipe.sv
// tb_gate_unit_pipe: queue-model scoreboard for WIDTH=4 and WIDTH=8 units plus directed literal checks.
module tb_gate_unit_pipe;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  gate_unit_pipe_if #(.WIDTH(4)) b4();
  gate_unit_pipe_if #(.WIDTH(8)) b8();
  gate_unit_pipe #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus_if(b4));
  gate_unit_pipe #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus_if(b8));
  int n_chk = 0, n_fail = 0;
  logic [7:0] q4[$], q8[$];
  function automatic logic [7:0] ref_y(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b, input int w);
    logic [7:0] r;
    case (op)
      3'd0: r = a & b;
      3'd1: r = a | b;
      3'd2: r = a ^ b;
      3'd3: r = ~(a & b);
      3'd4: r = ~(a | b);
      3'd5: r = ~(a ^ b);
      3'd6: r = a & ~b;
      default: r = ~a;
    endcase
    return w == 8 ? r : r & 8'h0F;
  endfunction
  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask
  always @(posedge clk or negedge rst_n) begin : model
    logic acc4, drn4, acc8, drn8;
    if (!rst_n) begin
      q4.delete();
      q8.delete();
    end else begin
      acc4 = b4.in_valid && q4.size() < 2;
      drn4 = b4.out_ready && q4.size() > 0;
      acc8 = b8.in_valid && q8.size() < 2;
      drn8 = b8.out_ready && q8.size() > 0;
      if (drn4) void'(q4.pop_front());
      if (acc4) q4.push_back(ref_y(b4.op, {4'b0, b4.a}, {4'b0, b4.b}, 4));
      if (drn8) void'(q8.pop_front());
      if (acc8) q8.push_back(ref_y(b8.op, b8.a, b8.b, 8));
    end
  end
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_ov4", 8'(b4.out_valid), 8'd0);
      chk("rst_ir4", 8'(b4.in_ready), 8'd1);
      chk("rst_y4", 8'(b4.y), 8'd0);
      chk("rst_ov8", 8'(b8.out_valid), 8'd0);
    end else begin
      chk("ir4", 8'(b4.in_ready), 8'(q4.size() < 2));
      chk("ov4", 8'(b4.out_valid), 8'(q4.size() > 0));
      if (q4.size() > 0) begin
        chk("y4", 8'(b4.y), q4[0]);
        chk("zero4", 8'(b4.zero), 8'(q4[0] == 8'd0));
        chk("par4", 8'(b4.parity), 8'(^q4[0]));
      end
      chk("ir8", 8'(b8.in_ready), 8'(q8.size() < 2));
      chk("ov8", 8'(b8.out_valid), 8'(q8.size() > 0));
      if (q8.size() > 0) begin
        chk("y8", b8.y, q8[0]);
        chk("zero8", 8'(b8.zero), 8'(q8[0] == 8'd0));
        chk("par8", 8'(b8.parity), 8'(^q8[0]));
      end
    end
  end
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic drv4(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b, input logic v);
    b4.op = op;
    b4.a = a;
    b4.b = b;
    b4.in_valid = v;
  endtask
  logic [3:0] exp2[8] = '{4'h5, 4'hF, 4'hA, 4'hA, 4'h0, 4'h5, 4'hA, 4'h0};
  initial begin
    drv4(3'd0, 4'h0, 4'h0, 1'b0);
    b4.out_ready = 1'b0;
    b8.in_valid = 1'b0;
    b8.op = 3'd0;
    b8.a = 8'h00;
    b8.b = 8'h00;
    b8.out_ready = 1'b0;
    #12;
    chk("reset_ov", 8'(b4.out_valid), 8'd0);
    chk("reset_ir", 8'(b4.in_ready), 8'd1);
    chk("reset_flags", {6'd0, b4.zero, b4.parity}, 8'd0);
    rst_n = 1'b1;
    cyc();
    // single AND with latency 1, valid for exactly one cycle
    drv4(3'd0, 4'hA, 4'hC, 1'b1);
    b4.out_ready = 1'b1;
    cyc();
    b4.in_valid = 1'b0;
    chk("t1_y", 8'(b4.y), 8'h08);
    chk("t1_flags", {6'd0, b4.zero, b4.parity}, 8'd1);
    chk("t1_ov", 8'(b4.out_valid), 8'd1);
    cyc();
    chk("t1_ov_drop", 8'(b4.out_valid), 8'd0);
    for (int i = 0; i < 8; i++) begin
      drv4(3'(i), 4'hF, 4'h5, 1'b1);
      cyc();
      chk("t2_y", 8'(b4.y), 8'(exp2[i]));
      chk("t2_zero", 8'(b4.zero), 8'(i == 4 || i == 7));
    end
    b4.in_valid = 1'b0;
    cyc();
    // backpressure fills both entries, then drains in order
    b4.out_ready = 1'b0;
    drv4(3'd0, 4'hA, 4'hC, 1'b1);
    cyc();
    chk("t3_ir_a", 8'(b4.in_ready), 8'd1);
    drv4(3'd1, 4'h3, 4'h4, 1'b1);
    cyc();
    chk("t3_ir_b", 8'(b4.in_ready), 8'd0);
    drv4(3'd2, 4'hF, 4'h1, 1'b1);
    cyc();
    chk("t3_ir_c", 8'(b4.in_ready), 8'd0);
    chk("t3_hold", 8'(b4.y), 8'h08);
    b4.out_ready = 1'b1;
    cyc();
    chk("t3_y1", 8'(b4.y), 8'h07);
    chk("t3_reopen", 8'(b4.in_ready), 8'd1);
    cyc();
    chk("t3_y2", 8'(b4.y), 8'h0E);
    b4.in_valid = 1'b0;
    cyc();
    chk("t3_empty", 8'(b4.out_valid), 8'd0);
    for (int i = 0; i < 10; i++) begin
      drv4(3'(i % 8), 4'(i), 4'(15 - i), 1'b1);
      cyc();
      chk("t4_ov", 8'(b4.out_valid), 8'd1);
      chk("t4_ir", 8'(b4.in_ready), 8'd1);
      chk("t4_y", 8'(b4.y), ref_y(3'(i % 8), 8'(i), 8'(15 - i), 4));
    end
    b4.in_valid = 1'b0;
    cyc();
    // reset with both entries occupied
    b4.out_ready = 1'b0;
    drv4(3'd0, 4'hF, 4'hF, 1'b1);
    cyc();
    drv4(3'd1, 4'h1, 4'h2, 1'b1);
    cyc();
    b4.in_valid = 1'b0;
    chk("t5_full", 8'(b4.in_ready), 8'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_ov", 8'(b4.out_valid), 8'd0);
    chk("t5_y", 8'(b4.y), 8'd0);
    chk("t5_ir", 8'(b4.in_ready), 8'd1);
    #3 rst_n = 1'b1;
    drv4(3'd2, 4'h5, 4'h3, 1'b1);
    b4.out_ready = 1'b1;
    cyc();
    chk("t5_after_ov", 8'(b4.out_valid), 8'd1);
    chk("t5_after_y", 8'(b4.y), 8'h06);
    b4.in_valid = 1'b0;
    cyc();
    b8.op = 3'd2;
    b8.a = 8'hF0;
    b8.b = 8'hFF;
    b8.in_valid = 1'b1;
    b8.out_ready = 1'b1;
    cyc();
    b8.in_valid = 1'b0;
    chk("t6_y", b8.y, 8'h0F);
    chk("t6_par", 8'(b8.parity), 8'd0);
    chk("t6_zero", 8'(b8.zero), 8'd0);
    for (int i = 0; i < 1000; i++) begin
      drv4(3'($urandom), 4'($urandom), 4'($urandom), 1'($urandom));
      b4.out_ready = $urandom_range(0, 3) != 0;
      b8.op = 3'($urandom);
      b8.a = 8'($urandom);
      b8.b = 8'($urandom);
      b8.in_valid = 1'($urandom);
      b8.out_ready = $urandom_range(0, 2) == 0;
      cyc();
    end
    b4.in_valid = 1'b0;
    b8.in_valid = 1'b0;
    b4.out_ready = 1'b1;
    b8.out_ready = 1'b1;
    repeat (3) cyc();
    chk("final_empty4", 8'(b4.out_valid), 8'd0);
    chk("final_empty8", 8'(b8.out_valid), 8'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
